// File: rtl/ifns_rx_word_assembler.sv
// rtl/ifns_rx_word_assembler.sv - packs NUM_CHUNKS decoded IFNS chunks into one wide word
// Output word is held under valid/ready; words completing while it is occupied are dropped.
module ifns_rx_word_assembler #(
  parameter int DATA_W     = 5,
  parameter int NUM_CHUNKS = 4,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_valid,
  input  logic                          frame_start,
  output logic [DATA_W*NUM_CHUNKS-1:0]  word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [$clog2(NUM_CHUNKS)-1:0] chunk_cnt
);

  localparam int WORD_W = DATA_W * NUM_CHUNKS;
  localparam int CNT_W  = $clog2(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] merged;
  logic [CNT_W-1:0]  slot;
  logic [CNT_W-1:0]  pos;
  logic              complete;
  logic              accept;
  logic              drop;

  // frame_start forces the incoming chunk into slot 0 regardless of the counter
  always_comb begin
    slot   = frame_start ? '0 : chunk_cnt;
    pos    = LSB_FIRST ? slot : (LAST - slot);
    merged = asm_q;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (CNT_W'(k) == pos) merged[k*DATA_W +: DATA_W] = din;
    end
  end

  assign complete = din_valid && !frame_start && (chunk_cnt == LAST);
  assign accept   = !word_valid || word_ready;
  assign drop     = complete && !accept;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= '0;
      chunk_cnt <= '0;
    end else begin
      if (din_valid) asm_q <= merged;
      if (frame_start) begin
        chunk_cnt <= din_valid ? CNT_W'(1) : '0;
      end else if (din_valid) begin
        chunk_cnt <= complete ? '0 : chunk_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (complete && accept) begin
      word_out   <= merged;
      word_valid <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // a drop in the same cycle as ovf_clr keeps the flag set
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifns_rx_word_assembler.sv
// tb/tb_ifns_rx_word_assembler.sv - directed bench for ifns_rx_word_assembler
// Two instances share stimulus: LSB-first (main) and MSB-first (packing order only).
module tb_ifns_rx_word_assembler;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [4:0]  din;
  logic        din_valid;
  logic        frame_start;
  logic        word_ready;
  logic        ovf_clr;
  logic [19:0] word_out;
  logic        word_valid;
  logic        overflow;
  logic [1:0]  chunk_cnt;
  logic [19:0] m_word_out;
  logic        m_word_valid;
  logic        m_overflow;
  logic [1:0]  m_chunk_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ifns_rx_word_assembler #(.DATA_W(5), .NUM_CHUNKS(4), .LSB_FIRST(1'b1)) dut (
    .clock(clock), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .overflow(overflow), .ovf_clr(ovf_clr),
    .chunk_cnt(chunk_cnt)
  );

  ifns_rx_word_assembler #(.DATA_W(5), .NUM_CHUNKS(4), .LSB_FIRST(1'b0)) dut_msb (
    .clock(clock), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .word_out(m_word_out), .word_valid(m_word_valid),
    .word_ready(word_ready), .overflow(m_overflow), .ovf_clr(ovf_clr),
    .chunk_cnt(m_chunk_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chunk(input logic [4:0] d);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = 5'h15;
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_start = 1'b0;
    word_ready = 1'b1; ovf_clr = 1'b0;
    tick();
    chk("rst_word_out", word_out, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cnt", chunk_cnt, 0);
    rst_n = 1'b1;
    tick();

    // LSB/MSB packing
    chunk(5'h01); chk("pk_cnt1", chunk_cnt, 1); chk("pk_valid1", word_valid, 0);
    chunk(5'h02); chk("pk_cnt2", chunk_cnt, 2);
    chunk(5'h03); chk("pk_cnt3", chunk_cnt, 3); chk("pk_valid3", word_valid, 0);
    chunk(5'h04); chk("pk_cnt0", chunk_cnt, 0);
    chk("pk_valid", word_valid, 1);
    chk("pk_lsb_word", word_out, 20'h20C41);
    chk("pk_msb_word", m_word_out, 20'h08864);
    tick();
    chk("pk_consumed", word_valid, 0);

    // gapped input
    chunk(5'h1F); tick(); tick(); chk("gap_v1", word_valid, 0);
    chunk(5'h00); tick(); tick(); chk("gap_v2", word_valid, 0);
    chunk(5'h1F); tick(); tick(); chk("gap_v3", word_valid, 0);
    chk("gap_cnt", chunk_cnt, 3);
    chunk(5'h00);
    chk("gap_valid", word_valid, 1);
    chk("gap_word", word_out, 20'h07C1F);
    tick();

    // completion coinciding with consume: back-to-back words
    word_ready = 1'b0;
    chunk(5'h01); chunk(5'h02); chunk(5'h03); chunk(5'h04);
    chunk(5'h05); chunk(5'h06); chunk(5'h07);
    chk("b2b_hold", word_out, 20'h20C41);
    word_ready = 1'b1;
    chunk(5'h08);
    chk("b2b_valid", word_valid, 1);
    chk("b2b_word", word_out, 20'h41CC5);
    chk("b2b_no_ovf", overflow, 0);
    tick();
    chk("b2b_consumed", word_valid, 0);

    // backpressure and overflow
    word_ready = 1'b0;
    chunk(5'h0A); chunk(5'h0B); chunk(5'h0C); chunk(5'h0D);
    chk("bp_valid", word_valid, 1);
    chk("bp_word", word_out, 20'h6B16A);
    chunk(5'h11); chunk(5'h12); chunk(5'h13);
    chk("bp_no_ovf", overflow, 0);
    chunk(5'h14);
    chk("bp_ovf", overflow, 1);
    chk("bp_held", word_out, 20'h6B16A);
    chk("bp_held_v", word_valid, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("bp_ovf_clr", overflow, 0);
    chunk(5'h01); chunk(5'h02); chunk(5'h03);
    ovf_clr = 1'b1; chunk(5'h04); ovf_clr = 1'b0;
    chk("bp_set_wins", overflow, 1);
    chk("bp_held2", word_out, 20'h6B16A);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("bp_ovf_clr2", overflow, 0);
    word_ready = 1'b1;
    tick();
    chk("bp_consumed", word_valid, 0);

    // resync with frame_start
    chunk(5'h1E);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("fs_idle_cnt", chunk_cnt, 0);
    chunk(5'h1E); chunk(5'h1D);
    chk("fs_cnt2", chunk_cnt, 2);
    frame_start = 1'b1; chunk(5'h05); frame_start = 1'b0;
    chk("fs_cnt1", chunk_cnt, 1);
    chunk(5'h06); chunk(5'h07);
    chk("fs_no_partial", word_valid, 0);
    chunk(5'h08);
    chk("fs_valid", word_valid, 1);
    chk("fs_word", word_out, 20'h41CC5);

    // reset mid-word (word held, partial in progress)
    word_ready = 1'b0;
    chunk(5'h01); chunk(5'h02); chunk(5'h03);
    chk("rm_cnt3", chunk_cnt, 3);
    rst_n = 1'b0;
    #2;
    chk("rm_word_out", word_out, 0);
    chk("rm_valid", word_valid, 0);
    chk("rm_cnt", chunk_cnt, 0);
    chk("rm_overflow", overflow, 0);
    tick();
    rst_n = 1'b1;
    word_ready = 1'b1;
    tick();
    chunk(5'h04); chunk(5'h03); chunk(5'h02);
    chk("rm_no_early", word_valid, 0);
    chunk(5'h01);
    chk("rm_valid2", word_valid, 1);
    chk("rm_word", word_out, 20'h08864);
    chk("rm_msb_word", m_word_out, 20'h20C41);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
